clk_gate_ctrl: RTL



---
 rtl/clk_gate_ctrl_pkg.sv | 21 ++
 rtl/clk_gate_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl_pkg.sv
// ============================================================================
// Module  : glbl_clk_gate_ctrl_pkg
// Brief   : Shared state encoding and widths for the clock-gate controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package glbl_clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_COUNT = 2'd1,
    ST_OFF   = 2'd2,
    ST_WAKE  = 2'd3
  } clk_gate_state_e;

  localparam int WakeCntWidth = 8;

endpackage

`default_nettype wire

// File: rtl/clk_gate_ctrl.sv
// ============================================================================
// Module  : clk_gate_ctrl
// Brief   : Idle-detect FSM driving clk_gate.ena_i, with four-phase wake
//           handshake. Optional DFT force port under GLBL_CLK_GATE_CTRL_DFT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_gate_ctrl
  import glbl_clk_gate_ctrl_pkg::*;
#(
  parameter int IdleWidth = 8,
  parameter int WakeDelay = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 busy_i,
  input  logic [IdleWidth-1:0] idle_thresh_i,
  input  logic                 wake_req_i,
`ifdef GLBL_CLK_GATE_CTRL_DFT_EN
  input  logic                 dft_force_i,
`endif
  output logic                 wake_ack_o,
  output logic                 ena_o,
  output logic [1:0]           state_o
);

  generate
    if (WakeDelay < 1 || WakeDelay > 255) begin : g_bad_wake_delay
      $error("clk_gate_ctrl: WakeDelay must be in 1..255");
    end
  endgenerate

  localparam logic [WakeCntWidth-1:0] WakeLast = WakeCntWidth'(WakeDelay - 1);

  clk_gate_state_e             state_q, state_d;
  logic [IdleWidth-1:0]        cnt_q, cnt_d;
  logic [WakeCntWidth-1:0]     wcnt_q, wcnt_d;
  logic                        ena_q, ena_d;
  logic                        ack_q, ack_d;
  logic                        wake_cond;

  assign wake_cond = busy_i | wake_req_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_RUN: begin
        if (!wake_cond && (idle_thresh_i != '0)) begin
          state_d = ST_COUNT;
          cnt_d   = '0;
        end
      end
      ST_COUNT: begin
        // A zero threshold means gating was disabled mid-count: fall back to RUN.
        if (wake_cond || (idle_thresh_i == '0)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q >= idle_thresh_i - IdleWidth'(1)) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q + IdleWidth'(1);
        end
      end
      ST_OFF: begin
        if (wake_cond) begin
          state_d = ST_WAKE;
          wcnt_d  = '0;
        end
      end
      ST_WAKE: begin
        if (wcnt_q == WakeLast) begin
          state_d = ST_RUN;
        end else begin
          wcnt_d = wcnt_q + WakeCntWidth'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
`ifdef GLBL_CLK_GATE_CTRL_DFT_EN
    if (dft_force_i) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      wcnt_d  = '0;
    end
`endif
    ena_d = (state_d != ST_OFF);
    ack_d = wake_req_i & (state_d == ST_RUN);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      ena_q   <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      ena_q   <= ena_d;
      ack_q   <= ack_d;
    end
  end

`ifdef GLBL_CLK_GATE_CTRL_DFT_EN
  assign ena_o = ena_q | dft_force_i;
`else
  assign ena_o = ena_q;
`endif
  assign wake_ack_o = ack_q;
  assign state_o    = state_q;

endmodule

`default_nettype wire
